pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 9, is the width of all PC, offset and target values.
REQ-002 Parameter RESET_PC, default 0, is the PC value loaded on reset and on restart from HALT.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: level request to leave IDLE or HALT and begin fetching.
REQ-006 Port halt_req, input, 1: request to stop fetching after the current cycle.
REQ-007 Port stall, input, 1: hold pc_out unchanged (pipeline hazard).
REQ-008 Port branch_taken, input, 1: a branch resolved taken this cycle.
REQ-009 Port branch_pc, input, INST_ADDR_WIDTH: address of the resolving branch.
REQ-010 Port branch_offset, input, INST_ADDR_WIDTH: two's-complement offset added to branch_pc.
REQ-011 Port pc_out, output, INST_ADDR_WIDTH: current fetch address to instruction memory.
REQ-012 Port pc_valid, output, 1: pc_out is a live fetch address this cycle.
REQ-013 Port flush, output, 1: one-cycle pulse; younger fetched instructions are squashed.
REQ-014 Port halted, output, 1: high while in HALT.
REQ-015 Port trap, output, 1: overflow-trap status (see Configuration).

Function
REQ-016 States: IDLE (00), RUN (01), HALT (10); encoding 11 is unreachable and SHALL recover to IDLE on the next edge.
REQ-017 IDLE -> RUN when start=1; pc_out=RESET_PC; pc_valid becomes 1 in the cycle after the transition.
REQ-018 In RUN, the next-PC priority is branch_taken > stall > increment.
REQ-019 branch_taken in RUN: pc_out <= branch_pc + branch_offset, truncated mod 2^INST_ADDR_WIDTH; flush=1 in the following cycle only.
REQ-020 stall in RUN without branch_taken: pc_out is held and pc_valid stays 1.
REQ-021 Neither branch_taken nor stall in RUN: pc_out <= pc_out + 1, mod 2^INST_ADDR_WIDTH.
REQ-022 Branch and stall in the same cycle: the branch wins and the stall is ignored for that edge.
REQ-023 halt_req in RUN: RUN -> HALT; a branch_taken in the same cycle still updates pc_out and pulses flush.
REQ-024 In HALT: pc_valid=0 and halted=1; pc_out is held; branch_taken and stall are ignored.
REQ-025 HALT -> RUN when start=1 and halt_req=0: pc_out <= RESET_PC; halt_req has priority over start.
REQ-026 In IDLE: pc_valid=0 and halted=0; branch_taken, stall and halt_req are ignored.
REQ-027 Latency: one cycle from branch_taken to the target appearing on pc_out; no combinational path from any input to pc_out.
REQ-028 flush is registered and never asserts outside the cycle after an accepted branch.

Reset
REQ-029 While reset=1 at an edge: state=IDLE, pc_out=RESET_PC, pc_valid=0, flush=0, halted=0, trap=0.
REQ-030 reset overrides all other inputs, including mid-branch and in HALT; any pending flush is dropped.

Configuration
REQ-031 Macro PC_OVERFLOW_TRAP_EN defined: an increment from all-ones in RUN enters HALT instead of wrapping; pc_out is held at all-ones and trap is set sticky until reset or restart.
REQ-032 PC_OVERFLOW_TRAP_EN undefined: the increment wraps to 0 silently; trap is tied to 0.
REQ-033 Branch-target arithmetic wraps in both builds; only the sequential increment traps.

Structure
REQ-034 A shared package pc_seq_pkg SHALL hold the state enumeration and the state-width constant.
REQ-035 Target computation SHALL be one sub-module instance, branch_adder (pc_in, branch_offset -> branch_target); the increment is inline.

Verification
REQ-036 Reset, start, 4 idle cycles -> pc_out sequence 0,1,2,3,4 with pc_valid=1 from the cycle after start.
REQ-037 branch_taken with branch_pc=5 and offset=0x1FE (-2) -> pc_out=3 next cycle, flush high for exactly one cycle.
REQ-038 stall and branch_taken together (branch_pc=10, offset=4) -> pc_out=14; stall alone for 3 cycles -> pc_out constant.
REQ-039 halt_req at pc=7, then start -> halted=1 and pc_valid=0 while halted; after start, pc_out=0 and RUN resumes.
REQ-040 Run to pc=0x1FF and increment -> with the macro: halted=1, trap=1, pc_out=0x1FF; without it: pc_out=0, trap=0.
REQ-041 reset asserted the cycle after a branch -> flush=0 and pc_out=RESET_PC next cycle, state=IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: the FSM state encoding and its width.
package pc_seq_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bus between the pipeline (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned INST_ADDR_WIDTH = 9
) ();

    logic                       start;
    logic                       halt_req;
    logic                       stall;
    logic                       branch_taken;
    logic [INST_ADDR_WIDTH-1:0] branch_pc;
    logic [INST_ADDR_WIDTH-1:0] branch_offset;
    logic [INST_ADDR_WIDTH-1:0] pc_out;
    logic                       pc_valid;
    logic                       flush;
    logic                       halted;
    logic                       trap;

    modport master (
        output start, halt_req, stall, branch_taken, branch_pc, branch_offset,
        input  pc_out, pc_valid, flush, halted, trap
    );

    modport slave (
        input  start, halt_req, stall, branch_taken, branch_pc, branch_offset,
        output pc_out, pc_valid, flush, halted, trap
    );

endinterface

// File: rtl/branch_adder.sv
// Branch target: pc_in plus a two's-complement offset, wrapping modulo 2^INST_ADDR_WIDTH.
module branch_adder #(
    parameter int unsigned INST_ADDR_WIDTH = 9
) (
    input  logic [INST_ADDR_WIDTH-1:0] pc_in,
    input  logic [INST_ADDR_WIDTH-1:0] branch_offset,
    output logic [INST_ADDR_WIDTH-1:0] branch_target
);

    assign branch_target = pc_in + branch_offset;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: IDLE/RUN/HALT fetch-address generator with branch redirect and flush.
// Optional PC_OVERFLOW_TRAP_EN: sequential increment past all-ones halts and sets trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned                INST_ADDR_WIDTH = 9,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.slave    bus
);

    state_e                     r_state, w_state_d;
    logic [INST_ADDR_WIDTH-1:0] r_pc, w_pc_d;
    logic                       r_flush, w_flush_d;
    logic                       r_trap, w_trap_d;
    logic [INST_ADDR_WIDTH-1:0] w_target;
    logic [INST_ADDR_WIDTH-1:0] w_pc_inc;

    branch_adder #(
        .INST_ADDR_WIDTH(INST_ADDR_WIDTH)
    ) u_branch_adder (
        .pc_in        (bus.branch_pc),
        .branch_offset(bus.branch_offset),
        .branch_target(w_target)
    );

    assign w_pc_inc = r_pc + 1'b1;

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_flush_d = 1'b0;
        w_trap_d  = r_trap;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = StRun;
                    w_pc_d    = RESET_PC;
                end
            end
            StRun: begin
                // Branch beats stall; a halt request freezes the sequential increment.
                if (bus.branch_taken) begin
                    w_pc_d    = w_target;
                    w_flush_d = 1'b1;
                end else if (!bus.stall && !bus.halt_req) begin
`ifdef PC_OVERFLOW_TRAP_EN
                    if (&r_pc) begin
                        w_state_d = StHalt;
                        w_trap_d  = 1'b1;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
`else
                    w_pc_d = w_pc_inc;
`endif
                end
                if (bus.halt_req) begin
                    w_state_d = StHalt;
                end
            end
            StHalt: begin
                if (bus.start && !bus.halt_req) begin
                    w_state_d = StRun;
                    w_pc_d    = RESET_PC;
                    w_trap_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_flush <= w_flush_d;
            r_trap  <= w_trap_d;
        end
    end

    assign bus.pc_out   = r_pc;
    assign bus.pc_valid = (r_state == StRun);
    assign bus.halted   = (r_state == StHalt);
    assign bus.flush    = r_flush;
    assign bus.trap     = r_trap;

endmodule
